// File: rtl/itrx_aib_phy_lat_pkg.sv
// rtl/itrx_aib_phy_lat_pkg.sv - shared types and constants for the AIB PHY trim-latch write path
package itrx_aib_phy_lat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_HOLD   = 2'd3
    } lat_wr_state_e;

    localparam int CNT_W       = 4;
    localparam int CYC_MIN     = 1;
    localparam int CYC_MAX     = 15;
    localparam int NUM_LAT_MIN = 2;
    localparam int NUM_LAT_MAX = 32;

endpackage

// File: rtl/itrx_aib_phy_lat_wr_ctrl_if.sv
// rtl/itrx_aib_phy_lat_wr_ctrl_if.sv - write-request valid/ready channel into the trim-latch sequencer
interface itrx_aib_phy_lat_wr_ctrl_if #(
    parameter int AW = 3,
    parameter int DW = 8
) ();
    logic          req_vld;
    logic          req_rdy;
    logic [AW-1:0] req_addr;
    logic          req_bcast;
    logic [DW-1:0] req_data;

    modport master (output req_vld, output req_addr, output req_bcast, output req_data, input req_rdy);
    modport slave  (input req_vld, input req_addr, input req_bcast, input req_data, output req_rdy);
endinterface

// File: rtl/itrx_aib_phy_lat_wr_ctrl.sv
// rtl/itrx_aib_phy_lat_wr_ctrl.sv - write sequencer producing setup/enable/hold windows for a std-cell latch bank
module itrx_aib_phy_lat_wr_ctrl
    import itrx_aib_phy_lat_pkg::*;
#(
    parameter int NUM_LAT  = 8,
    parameter int DW       = 8,
    parameter int AW       = 3,
    parameter int EN_CYC   = 1,
    parameter int HOLD_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    itrx_aib_phy_lat_wr_ctrl_if.slave  req,
    output logic [DW-1:0]              lat_din,
    output logic [NUM_LAT-1:0]         lat_en,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    if (NUM_LAT < NUM_LAT_MIN || NUM_LAT > NUM_LAT_MAX || DW < 1 ||
        AW < $clog2(NUM_LAT) || AW > 31 ||
        EN_CYC < CYC_MIN || EN_CYC > CYC_MAX ||
        HOLD_CYC < CYC_MIN || HOLD_CYC > CYC_MAX) begin : g_param_chk
        $error("itrx_aib_phy_lat_wr_ctrl: illegal parameter set");
    end

    localparam logic [CNT_W-1:0]   EN_LD       = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0]   HOLD_LD     = CNT_W'(HOLD_CYC - 1);
    localparam logic [AW:0]        NUM_LAT_CMP = (AW + 1)'(NUM_LAT);
    localparam logic [NUM_LAT-1:0] EN_ONE      = {{(NUM_LAT - 1){1'b0}}, 1'b1};

    lat_wr_state_e      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [AW-1:0]      addr_q;
    logic               bcast_q;
    logic               rdy_q;
    logic [DW-1:0]      lat_din_q;
    logic [NUM_LAT-1:0] lat_en_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               accept;
    logic               addr_oor;
    logic [NUM_LAT-1:0] lat_en_d;

    assign accept   = req.req_vld & rdy_q;
    assign addr_oor = !req.req_bcast && ({1'b0, req.req_addr} >= NUM_LAT_CMP);

    // Enable pattern is decoded from the captured request so it is stable for the whole window.
    always_comb begin
        lat_en_d = '0;
        if (bcast_q) lat_en_d = '1;
        else         lat_en_d = EN_ONE << addr_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            bcast_q   <= 1'b0;
            rdy_q     <= 1'b0;
            lat_din_q <= '0;
            lat_en_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        if (addr_oor) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q    <= req.req_addr;
                            bcast_q   <= req.req_bcast;
                            lat_din_q <= req.req_data;
                            rdy_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    lat_en_q <= lat_en_d;
                    cnt_q    <= EN_LD;
                    state_q  <= ST_ENABLE;
                end
                ST_ENABLE: begin
                    if (cnt_q == '0) begin
                        lat_en_q <= '0;
                        cnt_q    <= HOLD_LD;
                        state_q  <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req.req_rdy = rdy_q;
    assign lat_din     = lat_din_q;
    assign lat_en      = lat_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_itrx_aib_phy_lat_wr_ctrl.sv
// tb/tb_itrx_aib_phy_lat_wr_ctrl.sv - scoreboard bench for the trim-latch write sequencer with a behavioural latch bank
module tb_itrx_aib_phy_lat_wr_ctrl;

    typedef struct packed {
        logic            is_err;
        int              cyc;
        logic [7:0]      en;
        logic [7:0][7:0] bank;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    itrx_aib_phy_lat_wr_ctrl_if #(.AW(3), .DW(8)) if0 ();
    itrx_aib_phy_lat_wr_ctrl_if #(.AW(3), .DW(8)) if1 ();

    logic [7:0] lat_din0, lat_din1, lat_en0;
    logic [5:0] lat_en1;
    logic       busy0, done0, err0, busy1, done1, err1;

    itrx_aib_phy_lat_wr_ctrl #(.NUM_LAT(8), .DW(8), .AW(3), .EN_CYC(1), .HOLD_CYC(1)) u0 (
        .clk(clk), .rstn(rstn), .req(if0), .lat_din(lat_din0), .lat_en(lat_en0),
        .busy(busy0), .done(done0), .err(err0));

    itrx_aib_phy_lat_wr_ctrl #(.NUM_LAT(6), .DW(8), .AW(3), .EN_CYC(3), .HOLD_CYC(2)) u1 (
        .clk(clk), .rstn(rstn), .req(if1), .lat_din(lat_din1), .lat_en(lat_en1),
        .busy(busy1), .done(done1), .err(err1));

    // Behavioural latch bank: transparent while enabled, cleared by the shared reset.
    logic [1:0][7:0][7:0] bank = '0;
    logic [1:0][7:0][7:0] mdl  = '0;
    always @(rstn or lat_en0 or lat_din0 or lat_en1 or lat_din1) begin
        if (!rstn) bank = '0;
        else begin
            for (int i = 0; i < 8; i++) if (lat_en0[i]) bank[0][i] = lat_din0;
            for (int i = 0; i < 6; i++) if (lat_en1[i]) bank[1][i] = lat_din1;
        end
    end

    function automatic int nl(input int d);   return (d == 0) ? 8 : 6; endfunction
    function automatic int enc(input int d);  return (d == 0) ? 1 : 3; endfunction
    function automatic int hc(input int d);   return (d == 0) ? 1 : 2; endfunction
    function automatic logic [7:0] mask(input int d); return (d == 0) ? 8'hFF : 8'h3F; endfunction
    function automatic logic rdy(input int d); return (d == 0) ? if0.req_rdy : if1.req_rdy; endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    exp_t       q [2][$];
    logic [7:0] pen [2], pdin [2], pulse_en [2];
    int         run [2], viol [2], done_cnt [2], acc_cnt [2];

    initial for (int d = 0; d < 2; d++) begin
        viol[d] = 0; done_cnt[d] = 0; acc_cnt[d] = 0; run[d] = 0; pen[d] = '0; pulse_en[d] = '0;
    end

    always @(negedge clk) begin
        logic [7:0] m_en, m_din;
        logic       m_dn, m_er;
        exp_t       m_e;
        for (int d = 0; d < 2; d++) begin
            m_en  = (d == 0) ? lat_en0  : {2'b00, lat_en1};
            m_din = (d == 0) ? lat_din0 : lat_din1;
            m_dn  = (d == 0) ? done0    : done1;
            m_er  = (d == 0) ? err0     : err1;
            if (!rstn) begin
                pen[d] = '0; run[d] = 0; pdin[d] = m_din;
            end else begin
                if (m_en != '0) begin
                    if (pen[d] == '0) begin pulse_en[d] = m_en; run[d] = 0; end
                    else if (m_en != pen[d]) viol[d]++;
                    run[d]++;
                    if (!$onehot(m_en) && m_en != mask(d)) viol[d]++;
                end
                if ((m_en != '0 || pen[d] != '0) && m_din != pdin[d]) viol[d]++;
                if (m_dn || m_er) begin
                    if (q[d].size() == 0) begin
                        check($sformatf("u%0d_unexpected_event", d), {62'd0, m_dn, m_er}, 64'd0);
                    end else begin
                        m_e = q[d].pop_front();
                        check($sformatf("u%0d_kind", d), m_er, m_e.is_err);
                        check($sformatf("u%0d_event_cyc", d), cyc, m_e.cyc);
                        check($sformatf("u%0d_bank", d), bank[d], m_e.bank);
                        if (!m_e.is_err) begin
                            check($sformatf("u%0d_en_pattern", d), pulse_en[d], m_e.en);
                            check($sformatf("u%0d_en_width", d), run[d], enc(d));
                            done_cnt[d]++;
                        end
                    end
                end
                pen[d] = m_en; pdin[d] = m_din;
            end
        end
    end

    task automatic drive(input int d, input logic v, input logic [2:0] a, input logic b, input logic [7:0] dt);
        if (d == 0) begin if0.req_vld = v; if0.req_addr = a; if0.req_bcast = b; if0.req_data = dt; end
        else        begin if1.req_vld = v; if1.req_addr = a; if1.req_bcast = b; if1.req_data = dt; end
    endtask

    task automatic idle();
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 1'b0, 8'h00);
        drive(1, 1'b0, 3'd0, 1'b0, 8'h00);
    endtask

    // Presents one request, waits for the handshake, then records the predicted outcome.
    task automatic send(input int d, input logic [2:0] a, input logic b, input logic [7:0] dt, output int acc);
        int   t;
        exp_t e;
        logic oor;
        @(negedge clk);
        drive(d, 1'b1, a, b, dt);
        t = 0;
        while (!rdy(d) && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            check($sformatf("u%0d_accept_timeout", d), 64'd1, 64'd0);
            drive(d, 1'b0, a, b, dt);
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        oor = !b && (int'(a) >= nl(d));
        if (!oor) begin
            if (b) for (int i = 0; i < nl(d); i++) mdl[d][i] = dt;
            else   mdl[d][a] = dt;
            acc_cnt[d]++;
        end
        e.is_err = oor;
        e.cyc    = oor ? acc : acc + enc(d) + hc(d) + 1;
        e.en     = oor ? 8'h00 : (b ? mask(d) : (8'h01 << a));
        e.bank   = mdl[d];
        q[d].push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && t < 100) begin @(negedge clk); t++; end
        check("drain_pending", q[0].size() + q[1].size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, t;
        drive(0, 1'b0, 3'd0, 1'b0, 8'h00);
        drive(1, 1'b0, 3'd0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("u0_reset_outs", {if0.req_rdy, busy0, done0, err0, lat_en0, lat_din0}, 64'd0);
        check("u1_reset_outs", {if1.req_rdy, busy1, done1, err1, lat_en1, lat_din1}, 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_reset", {if0.req_rdy, if1.req_rdy}, 2'b11);

        send(0, 3'd3, 1'b0, 8'hA5, a0);
        idle(); drain();
        check("single_bank", bank[0], 64'h00000000_A5000000);

        send(1, 3'd0, 1'b1, 8'h3C, a0);
        idle(); drain();
        check("bcast_bank", bank[1], 64'h0000_3C3C3C3C3C3C);

        send(1, 3'd7, 1'b0, 8'h55, a0);
        send(1, 3'd1, 1'b0, 8'h11, a1);
        idle(); drain();
        check("oor_next_accept", a1 - a0, 1);
        check("oor_bank", bank[1], 64'h0000_3C3C3C3C113C);

        send(0, 3'd0, 1'b0, 8'h10, a0);
        send(0, 3'd1, 1'b0, 8'h20, a1);
        send(0, 3'd2, 1'b0, 8'h30, a2);
        idle(); drain();
        check("b2b_gap1", a1 - a0, 4);
        check("b2b_gap2", a2 - a1, 4);
        check("b2b_bank", bank[0], 64'h00000000_A5302010);

        send(0, 3'd5, 1'b0, 8'h77, a0);
        t = 0;
        while (lat_en0 == 8'h00 && t < 20) begin @(negedge clk); t++; end
        check("rst_en_seen", lat_en0, 8'h20);
        #2 rstn = 1'b0;
        #1;
        check("rst_async_en", lat_en0, 8'h00);
        check("rst_async_busy_rdy", {busy0, if0.req_rdy}, 2'b00);
        q[0].delete(); q[1].delete();
        mdl = '0;
        acc_cnt[0] = done_cnt[0]; acc_cnt[1] = done_cnt[1];
        drive(0, 1'b0, 3'd0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("rst_bank_clear", bank, 128'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_rdy_after", {if0.req_rdy, if1.req_rdy}, 2'b11);
        repeat (6) @(negedge clk);

        for (int n = 0; n < 1000; n++)
            send(0, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 8'($urandom), a0);
        idle(); drain();
        for (int n = 0; n < 200; n++)
            send(1, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 8'($urandom), a0);
        idle(); drain();

        repeat (4) @(negedge clk);
        check("u0_done_count", done_cnt[0], acc_cnt[0]);
        check("u1_done_count", done_cnt[1], acc_cnt[1]);
        check("u0_invariants", viol[0], 0);
        check("u1_invariants", viol[1], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
